// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver.
// The receiver drives it as master; the host-side byte consumer is the slave.
interface uart_rx_if;
    logic       rd;
    logic [7:0] data;
    logic       rxrdy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        input  rd,
        output data, rxrdy, frame_err, overrun, parity_err
    );

    modport slave (
        output rd,
        input  data, rxrdy, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a ready/read byte handshake, framing and overrun flags.
// Define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int N  = CLKS_PER_BIT;
    localparam int H  = N / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          rx_s1;
    logic          rxs;
    logic          rx_prev;

    logic [7:0]    data_q;
    logic          rxrdy_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          perr_q;
    logic          perr_d;
    logic          done;
    logic          rd_hit;

    // Sync flops idle high so reset never fakes a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rxs     <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rxs     <= rx_s1;
            rx_prev <= rxs;
        end
    end

    assign done   = (state == STOP) && (cnt == CNT_LAST);
    assign rd_hit = bus.rd && rxrdy_q;

`ifdef UART_RX_PARITY_EN
    logic pbit;

    assign perr_d = (^shreg) != pbit;
`else
    assign perr_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            pbit  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rxs) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        idx   <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (idx == 3'd7) state <= PARITY;
`else
                        if (idx == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        pbit  <= rxs;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // A completing frame takes priority over a read in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 8'h00;
            rxrdy_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else if (done) begin
            data_q  <= shreg;
            rxrdy_q <= 1'b1;
            ferr_q  <= ~rxs;
            perr_q  <= perr_d;
            if (rd_hit)       ovr_q <= 1'b0;
            else if (rxrdy_q) ovr_q <= 1'b1;
        end else if (rd_hit) begin
            rxrdy_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end
    end

    assign bus.data       = data_q;
    assign bus.rxrdy      = rxrdy_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
    assign bus.parity_err = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit.
// Build with UART_RX_PARITY_EN defined to cover the parity frame format.
module tb_uart_rx;
  localparam int N = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + N / 2 + 10 * N + 1;
`else
  localparam int LAT = 2 + N / 2 + 9 * N + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_fall = 0;
  int lat = 0;
  logic [9:0] exp_q[$];
  logic rdy_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin : monitor
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rxrdy && !rdy_q) begin
        lat = cyc - t_fall;
        if (exp_q.size() == 0) begin
          check("spurious_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("data", {24'd0, bus.data}, {24'd0, e[7:0]});
          check("frame_err", {31'd0, bus.frame_err}, {31'd0, e[8]});
          check("parity_err", {31'd0, bus.parity_err}, {31'd0, e[9]});
        end
      end
      rdy_q = bus.rxrdy;
    end
  end

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic pbit,
                      input logic stopb, input int stop_len,
                      input logic push, input logic pe_exp);
    if (push) exp_q.push_back({pe_exp, ~stopb, d});
    t_fall = cyc;
    hold(1'b0, N);
    for (int k = 0; k < 8; k++) hold(d[k], N);
`ifdef UART_RX_PARITY_EN
    hold(pbit, N);
`else
    if (pbit === 1'bx) hold(1'b1, 0);
`endif
    hold(stopb, stop_len);
    if (!stopb) hold(1'b1, N);
  endtask

  task automatic send_ok(input logic [7:0] d, input logic push);
    send(d, ^d, 1'b1, N, push, 1'b0);
  endtask

  task automatic drain();
    int budget = 4 * N;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      check("frame_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic read_pulse();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_rxrdy"}, {31'd0, bus.rxrdy}, 32'd0);
    check({tag, "_ferr"}, {31'd0, bus.frame_err}, 32'd0);
    check({tag, "_ovr"}, {31'd0, bus.overrun}, 32'd0);
    check({tag, "_perr"}, {31'd0, bus.parity_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    bus.rd = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, bus.data}, 32'd0);
    check_clear("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // basic frame and pin-to-ready latency
    send_ok(8'h55, 1'b1);
    drain();
    check("latency", lat, LAT);
    check("f1_rxrdy", {31'd0, bus.rxrdy}, 32'd1);
    check("f1_ovr", {31'd0, bus.overrun}, 32'd0);
    read_pulse();
    check_clear("rd1");

    // short low glitch must not produce a frame
    hold(1'b0, 4);
    hold(1'b1, 3 * N);
    check("glitch_rxrdy", {31'd0, bus.rxrdy}, 32'd0);
    send_ok(8'hC3, 1'b1);
    drain();
    read_pulse();

    // stop bit low: framing error, no second frame on the held-low line
    send(8'hA3, ^8'hA3, 1'b0, 40, 1'b1, 1'b0);
    drain();
    repeat (12 * N) @(negedge clk);
    check("ferr_rxrdy", {31'd0, bus.rxrdy}, 32'd1);
    check("ferr_data", {24'd0, bus.data}, 32'hA3);
    check("ferr_ovr", {31'd0, bus.overrun}, 32'd0);
    read_pulse();
    check_clear("rd_ferr");

    // back-to-back frames without a read
    send_ok(8'h11, 1'b1);
    send_ok(8'h22, 1'b0);
    drain();
    check("ovr_data", {24'd0, bus.data}, 32'h22);
    check("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    check("ovr_rxrdy", {31'd0, bus.rxrdy}, 32'd1);
    check("ovr_ferr", {31'd0, bus.frame_err}, 32'd0);
    read_pulse();
    check_clear("rd_ovr");

    // reset in the middle of data bit 4
    t_fall = cyc;
    hold(1'b0, N);
    for (int k = 0; k < 4; k++) hold(k[0], N);
    hold(1'b1, N / 2);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_data", {24'd0, bus.data}, 32'd0);
    check_clear("mrst");
    rst = 1'b0;
    hold(1'b1, 3 * N);
    check("mrst_idle", {31'd0, bus.rxrdy}, 32'd0);
    send_ok(8'h7E, 1'b1);
    drain();
    check("post_rst_data", {24'd0, bus.data}, 32'h7E);
    read_pulse();

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1, N, 1'b1, 1'b1);
    drain();
    read_pulse();
    check_clear("rd_perr");
    send(8'h07, 1'b1, 1'b1, N, 1'b1, 1'b0);
    drain();
    read_pulse();
`endif

    repeat (2 * N) @(negedge clk);
    check("leftover_exp", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver. It is the receive-side counterpart of the team's UART transmitter: it consumes an 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed clocks-per-bit rate and presents each byte through a ready/read handshake. It sits between the board RX pin and the host-side byte consumer. Framing errors and overruns are flagged alongside the byte.

## Interface
- CLKS_PER_BIT, 5208, system clocks per bit (5208 = 9600 baud at 50 MHz); must be ≥ 8.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, asynchronous to clk, idle high.
- rd  input  1  read strobe; consumes the held byte when rxrdy=1.
- data  output  8  last received byte; reset 8'h00.
- rxrdy  output  1  byte held and unread; reset 0.
- frame_err  output  1  held byte had stop bit = 0; reset 0.
- overrun  output  1  an unread byte was overwritten; sticky until read; reset 0.
- parity_err  output  1  parity mismatch (see Configuration); reset 0.

## Operation
- rx passes through a 2-flop synchronizer, reset to 1. A third flop holds the previous synced value for edge detection. Only synced rx (rxs) is used below.
- Let N = CLKS_PER_BIT and H = N/2 (integer division). There is one bit counter (0..N-1) and one 3-bit data index.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: arm on a falling edge of rxs (prev=1, now=0); go to START with counter cleared. A level low without an edge does not arm, so no re-trigger on a break or a stuck-low line.
- START: at count H-1, sample rxs. If it is 0, go to DATA with counter cleared and index 0. If it is 1, treat it as a glitch and return to IDLE with no flags.
- DATA: at count N-1, shift rxs into the shift register MSB-side (LSB-first reception). After index 7, go to PARITY or STOP.
- STOP: at count N-1 (mid stop bit), complete the frame and return to IDLE in the same cycle:
  - data ← shift register;
  - frame_err ← ~rxs;
  - rxrdy ← 1;
  - overrun ← 1 if rxrdy was 1 and rd not asserted this cycle; otherwise overrun keeps its value.
- Read: rd & rxrdy with no completion in the same cycle clears rxrdy, frame_err, overrun and parity_err next cycle. rd while rxrdy=0 is ignored.
- Completion and read in the same cycle: the new byte wins. rxrdy stays 1, the new flags load, and overrun is cleared.
- Reset mid-frame: returns to IDLE and clears all outputs. A frame already in flight is dropped; re-arm needs a fresh falling edge.

## Timing
- t0 = first cycle rxs=0 in IDLE (2 clk after the pin edge).
- Start check at t0+H. Data bit k is sampled at t0+H+(k+1)·N. Stop bit is sampled at t0+H+9·N (t0+H+10·N with parity).
- data, rxrdy and flags are valid the cycle after the stop sample. Total pin-to-rxrdy latency is 2 + H + 9·N + 1 clocks (no parity).
- Back-to-back frames are supported: the FSM is in IDLE from mid stop bit, ready for the next start edge.
- Outputs change only on clk edges or async rst.

## Configuration
- UART_RX_PARITY_EN defined: an even-parity bit is expected after data bit 7 and sampled in PARITY at count N-1. The frame is 11 bits. parity_err ← (XOR of data bits) ≠ sampled bit, loaded with data at completion.
- Undefined: no PARITY state, 10-bit frame, parity_err tied 0.

## Test plan
- N=16, send 0x55 with no rd → rxrdy=1 and data=0x55 exactly 2+8+144+1 clk after the pin falls; frame_err=0, overrun=0.
- Glitch: rx low for 4 clk, then high → rxrdy remains 0, FSM back in IDLE; a following valid 0xC3 is received correctly.
- Stop bit = 0 with byte 0xA3, rx held low 40 clk then high → data=0xA3, frame_err=1, no second frame reported.
- Frames 0x11 then 0x22 with no rd → data=0x22, overrun=1. Pulse rd → rxrdy, overrun, frame_err all 0 next cycle.
- Assert rst at data bit 4 of a frame, release → all outputs 0; the next full frame 0x7E gives data=0x7E.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 → parity_err=1. 0x07 with parity bit 1 → parity_err=0.
